note_judge: RTL and testbench
=============================

Name: note_judge

Overview:
- Sits between the note engine/keypad scanner and the scorer.
- Timing-accurate replacement for the bare "keys == curr_note" compare.
- On each note it latches the one-hot note and hold length at a beat, requires a debounced matching press within the note's first beat, and requires that press held until the note's last beat. It then emits a single hit or miss pulse.
- Also maintains current and best combo counts for display.

Parameters:
- DEBOUNCE_CYC, 250000: CLOCK_50 cycles a key-match change must be stable before it is accepted (5 ms).
- GRACE_CYC, 2500000: maximum tolerated release gap while holding (50 ms); used only with the optional feature.
- COMBO_W, 8: width of the combo counters.

Ports:
- clk  in  1  CLOCK_50 system clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  game running level; 0 = idle
- game_clock  in  1  beat clock, asynchronous to clk, rising edge = beat
- keys  in  16  one-hot keypad state (bits 11:0 = notes, 15:12 = function keys)
- curr_note  in  12  one-hot current note; 0 = rest
- hold_length  in  4  beats the current note lasts
- hit_pulse  out  1  one-clk pulse: note judged correct
- miss_pulse  out  1  one-clk pulse: note judged wrong
- combo  out  COMBO_W  consecutive hits, saturating
- max_combo  out  COMBO_W  best combo since reset/start
- holding  out  1  1 while a valid press is being held (LED feedback)

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, sync/debounce registers 0.
- Beat detection
  - game_clock passes through a 2-FF synchronizer, then a rising-edge detector.
  - beat strobe = 1 clk, asserted 3 clk after the edge.
- Key match
  - raw_match = (keys[11:0] == latched_note) && (keys[15:12] == 0) && (latched_note != 0).
  - Debounced match changes only after raw_match has been stable for DEBOUNCE_CYC consecutive clk; the counter restarts on any raw change.
- Hold length: hold_length 0 is treated as 1. note_len = max(hold_length, 1).
- FSM:
  - IDLE: start=0. combo and max_combo hold their values. On start rising, clear combo and max_combo, go to SYNC.
  - SYNC: wait for a beat. On beat, latch curr_note and note_len, set beat_cnt=1. Go to REST if the note is 0, else WAIT_PRESS.
  - WAIT_PRESS:
    - Debounced match rises → HOLDING.
    - Beat arrives with no press → judge miss.
  - HOLDING: holding=1.
    - Debounced match falls → FAILED.
    - Beat with beat_cnt == note_len → judge hit.
    - Other beats increment beat_cnt.
  - FAILED: wait for beat_cnt == note_len at a beat, then judge miss.
  - REST: count beats to note_len. No judgement, combo unchanged.
  - Judge (same clk as the closing beat):
    - Pulse hit_pulse or miss_pulse for 1 clk.
    - Immediately latch the next curr_note/note_len, set beat_cnt=1, and enter WAIT_PRESS or REST. No dead cycle between notes.
  - Non-closing beats in WAIT_PRESS/FAILED/REST: increment beat_cnt. In WAIT_PRESS, a miss is judged at the first beat whatever note_len is, and the FSM goes to FAILED unless note_len == 1, in which case the note closes.
- Combo:
  - Hit: combo+1, saturating at 2^COMBO_W−1.
  - Miss: combo=0.
  - max_combo updates to combo's new value in the cycle after a hit if larger.
- start falling mid-note: return to IDLE next clk, no pulse emitted, combo/max_combo retained.
- reset mid-note: everything cleared asynchronously; a pending judgement is discarded.
- hit_pulse and miss_pulse are never high together. At most one pulse per note.

Optional Feature:
- Macro: NOTE_JUDGE_RELEASE_GRACE_EN.
- Defined: in HOLDING, a debounced release starts a grace counter.
  - If the match returns within GRACE_CYC clk, HOLDING continues with holding kept at 1.
  - Reaching GRACE_CYC → FAILED.
  - A closing beat during grace counts as a hit.
- Undefined: any debounced release in HOLDING → FAILED immediately. GRACE_CYC is unused.

Decomposition:
- Shared package note_judge_pkg:
  - FSM state encoding (IDLE, SYNC, WAIT_PRESS, HOLDING, FAILED, REST).
  - NOTE_W=12, KEY_W=16, HOLD_W=4.
  - Default debounce and grace cycle constants.
- One sub-module, beat_sync: 2-FF synchronizer plus rising-edge pulse generator for game_clock. Reusable by the scorer.

Test Plan (DEBOUNCE_CYC=4, GRACE_CYC=8 in the bench):
- reset high for 3 clk → all outputs 0. start=1, one beat, curr_note=0x001 hold 2, keys=0x0001 held 2 beats → one hit_pulse at the 2nd beat, combo=1, max_combo=1.
- curr_note=0x004 hold 1, keys stay 0 → miss_pulse at the next beat, combo 3→0, max_combo stays 3.
- keys=0x0004 bounce toggling every 2 clk, then stable → holding rises only after 4 stable clk.
- Hold 3 note, release after beat 1 for 20 clk → miss_pulse only at beat 3, never earlier. With the macro and a 5 clk release instead → hit_pulse.
- Correct note key plus keys[13] pressed → treated as no match → miss. Rest note (0x000) hold 2 with random keys → no pulses, combo unchanged.
- Force 255 hits → combo saturates at 255. start dropped mid-HOLDING → IDLE, no pulse. Async reset mid-note → outputs 0 within the same clk.

Source files
------------

// File: rtl/note_judge_pkg.sv
// Shared types and constants for the note judge and its beat synchronizer.
// Used by note_judge (optional feature macro: NOTE_JUDGE_RELEASE_GRACE_EN).
package note_judge_pkg;

  localparam int NOTE_W = 12;
  localparam int KEY_W  = 16;
  localparam int HOLD_W = 4;

  // 5 ms debounce and 50 ms release grace at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYC = 250000;
  localparam int DEFAULT_GRACE_CYC    = 2500000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SYNC       = 3'd1,
    ST_WAIT_PRESS = 3'd2,
    ST_HOLDING    = 3'd3,
    ST_FAILED     = 3'd4,
    ST_REST       = 3'd5
  } state_t;

  // A hold length of zero still occupies one beat.
  function automatic logic [HOLD_W-1:0] note_len_of(input logic [HOLD_W-1:0] hold);
    return (hold == '0) ? {{(HOLD_W-1){1'b0}}, 1'b1} : hold;
  endfunction

endpackage

// File: rtl/beat_sync.sv
// Brings an asynchronous beat clock into the clk domain and emits a one-clk
// strobe three clk after each rising edge (two sync stages plus a registered edge detect).
module beat_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  // chain_reg[SYNC_STAGES-1] is the synchronized level, chain_reg[SYNC_STAGES] its previous value
  logic [SYNC_STAGES:0] chain_reg;
  logic                 pulse_reg;

  genvar gi;
  generate
    for (gi = 0; gi <= SYNC_STAGES; gi++) begin : g_chain
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge reset) begin
          if (reset) chain_reg[gi] <= 1'b0;
          else       chain_reg[gi] <= async_in;
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge reset) begin
          if (reset) chain_reg[gi] <= 1'b0;
          else       chain_reg[gi] <= chain_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pulse_reg <= 1'b0;
    else       pulse_reg <= chain_reg[SYNC_STAGES-1] & ~chain_reg[SYNC_STAGES];
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/note_judge.sv
// Beat-accurate note judge: debounced press within the first beat, held to the last beat,
// one hit/miss pulse per note, combo tracking. Optional macro: NOTE_JUDGE_RELEASE_GRACE_EN.
module note_judge
  import note_judge_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
  parameter int GRACE_CYC    = DEFAULT_GRACE_CYC,
  parameter int COMBO_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               game_clock,
  input  logic [KEY_W-1:0]   keys,
  input  logic [NOTE_W-1:0]  curr_note,
  input  logic [HOLD_W-1:0]  hold_length,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] max_combo,
  output logic               holding
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  generate
    if (DEBOUNCE_CYC < 1 || GRACE_CYC < 1) begin : g_bad_params
      $error("note_judge: DEBOUNCE_CYC and GRACE_CYC must be at least 1");
    end
  endgenerate

  logic beat;

  beat_sync #(.SYNC_STAGES(2)) u_beat_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (game_clock),
    .pulse    (beat)
  );

  state_t              state_reg, state_next;
  logic [NOTE_W-1:0]   latched_note_reg, latched_note_next;
  logic [HOLD_W-1:0]   note_len_reg, note_len_next;
  logic [HOLD_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic                missed_reg, missed_next;
  logic                start_prev_reg;
  logic                hit_judge, miss_judge, clear_combo, load_note;
  logic                closing;

  // Debounce of the match against the latched note
  logic [DB_W-1:0]     db_cnt_reg;
  logic                match_db_reg;
  logic                raw_match, db_flip, match_rise, match_fall;

  assign raw_match = (keys[NOTE_W-1:0] == latched_note_reg) &&
                     (keys[KEY_W-1:NOTE_W] == '0) &&
                     (latched_note_reg != '0);
  assign db_flip    = (raw_match != match_db_reg) && (db_cnt_reg == DB_W'(DEBOUNCE_CYC - 1));
  assign match_rise = db_flip && raw_match;
  assign match_fall = db_flip && !raw_match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_reg   <= '0;
      match_db_reg <= 1'b0;
    end else if (raw_match == match_db_reg) begin
      db_cnt_reg   <= '0;
    end else if (db_flip) begin
      db_cnt_reg   <= '0;
      match_db_reg <= raw_match;
    end else begin
      db_cnt_reg   <= db_cnt_reg + 1'b1;
    end
  end

`ifdef NOTE_JUDGE_RELEASE_GRACE_EN
  localparam int GRACE_W = $clog2(GRACE_CYC + 1);
  logic               grace_active_reg, grace_active_next;
  logic [GRACE_W-1:0] grace_cnt_reg, grace_cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grace_active_reg <= 1'b0;
      grace_cnt_reg    <= '0;
    end else begin
      grace_active_reg <= grace_active_next;
      grace_cnt_reg    <= grace_cnt_next;
    end
  end
`endif

  assign closing = beat && (beat_cnt_reg == note_len_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      latched_note_reg <= '0;
      note_len_reg     <= '0;
      beat_cnt_reg     <= '0;
      missed_reg       <= 1'b0;
      start_prev_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      latched_note_reg <= latched_note_next;
      note_len_reg     <= note_len_next;
      beat_cnt_reg     <= beat_cnt_next;
      missed_reg       <= missed_next;
      start_prev_reg   <= start;
    end
  end

  always_comb begin
    state_next        = state_reg;
    latched_note_next = latched_note_reg;
    note_len_next     = note_len_reg;
    beat_cnt_next     = beat_cnt_reg;
    missed_next       = missed_reg;
    hit_judge         = 1'b0;
    miss_judge        = 1'b0;
    clear_combo       = 1'b0;
    load_note         = 1'b0;
`ifdef NOTE_JUDGE_RELEASE_GRACE_EN
    grace_active_next = grace_active_reg;
    grace_cnt_next    = grace_cnt_reg;
`endif

    if (state_reg != ST_IDLE && !start) begin
      // Game stopped mid-note: abandon it silently
      state_next = ST_IDLE;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (start && !start_prev_reg) begin
            clear_combo = 1'b1;
            state_next  = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (beat) load_note = 1'b1;
        end
        ST_WAIT_PRESS: begin
          if (beat) begin
            // No press by the first beat: the miss is reported now, not at the note end
            miss_judge = 1'b1;
            if (closing) begin
              load_note = 1'b1;
            end else begin
              missed_next   = 1'b1;
              beat_cnt_next = beat_cnt_reg + 1'b1;
              state_next    = ST_FAILED;
            end
          end else if (match_rise) begin
            state_next = ST_HOLDING;
          end
        end
        ST_HOLDING: begin
          if (closing) begin
            hit_judge = 1'b1;
            load_note = 1'b1;
          end else begin
            if (beat) beat_cnt_next = beat_cnt_reg + 1'b1;
`ifdef NOTE_JUDGE_RELEASE_GRACE_EN
            if (match_fall) begin
              grace_active_next = 1'b1;
              grace_cnt_next    = '0;
            end else if (grace_active_reg) begin
              if (match_rise) begin
                grace_active_next = 1'b0;
              end else if (grace_cnt_reg == GRACE_W'(GRACE_CYC - 1)) begin
                grace_active_next = 1'b0;
                state_next        = ST_FAILED;
              end else begin
                grace_cnt_next = grace_cnt_reg + 1'b1;
              end
            end
`else
            if (match_fall) state_next = ST_FAILED;
`endif
          end
        end
        ST_FAILED: begin
          if (closing) begin
            miss_judge = !missed_reg;
            load_note  = 1'b1;
          end else if (beat) begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
        ST_REST: begin
          if (closing)   load_note     = 1'b1;
          else if (beat) beat_cnt_next = beat_cnt_reg + 1'b1;
        end
        default: state_next = ST_IDLE;
      endcase
    end

    // The closing beat of one note is the opening beat of the next
    if (load_note) begin
      latched_note_next = curr_note;
      note_len_next     = note_len_of(hold_length);
      beat_cnt_next     = {{(HOLD_W-1){1'b0}}, 1'b1};
      missed_next       = 1'b0;
      state_next        = (curr_note == '0) ? ST_REST : ST_WAIT_PRESS;
`ifdef NOTE_JUDGE_RELEASE_GRACE_EN
      grace_active_next = 1'b0;
      grace_cnt_next    = '0;
`endif
    end
  end

  logic               hit_pulse_reg, miss_pulse_reg;
  logic [COMBO_W-1:0] combo_reg, max_combo_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_pulse_reg  <= 1'b0;
      miss_pulse_reg <= 1'b0;
      combo_reg      <= '0;
      max_combo_reg  <= '0;
    end else begin
      hit_pulse_reg  <= hit_judge;
      miss_pulse_reg <= miss_judge;
      if (clear_combo) begin
        combo_reg     <= '0;
        max_combo_reg <= '0;
      end else begin
        if (hit_judge) begin
          if (combo_reg != '1) combo_reg <= combo_reg + 1'b1;
        end else if (miss_judge) begin
          combo_reg <= '0;
        end
        // Best combo trails the hit by one clk, comparing the freshly bumped combo
        if (hit_pulse_reg && (combo_reg > max_combo_reg)) max_combo_reg <= combo_reg;
      end
    end
  end

  assign hit_pulse  = hit_pulse_reg;
  assign miss_pulse = miss_pulse_reg;
  assign combo      = combo_reg;
  assign max_combo  = max_combo_reg;
  assign holding    = (state_reg == ST_HOLDING);

endmodule

// File: tb/tb_note_judge.sv
// Scoreboard bench for note_judge: note tasks queue the expected pulse (kind, beat, combo),
// a negedge monitor pops and compares whenever hit_pulse or miss_pulse appears.
`timescale 1ns/1ps
module tb_note_judge;

  localparam int DEB   = 4;
  localparam int GRACE = 8;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  localparam int E_NONE = 0, E_HIT = 1, E_MISS_FIRST = 2, E_MISS_CLOSE = 3;
  localparam int M_PRESS = 0, M_GAP = 1, M_REST = 2, M_BOUNCE = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          game_clock = 1'b0;
  logic [15:0]   keys = '0;
  logic [11:0]   curr_note = '0;
  logic [3:0]    hold_length = '0;
  logic          hit_pulse, miss_pulse, holding;
  logic [CW-1:0] combo, max_combo;

  note_judge #(.DEBOUNCE_CYC(DEB), .GRACE_CYC(GRACE), .COMBO_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .game_clock  (game_clock),
    .keys        (keys),
    .curr_note   (curr_note),
    .hold_length (hold_length),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .combo       (combo),
    .max_combo   (max_combo),
    .holding     (holding)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit hit;
    int beat;
    int combo;
  } exp_t;

  exp_t exp_q[$];
  int   compared    = 0;
  int   mismatched  = 0;
  int   beat_no     = 0;
  int   combo_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && (hit_pulse || miss_pulse)) begin
      compared++;
      if (hit_pulse && miss_pulse) begin
        mismatched++;
        $display("FAIL pulse_exclusive: hit and miss together at beat %0d", beat_no);
      end else if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pulse: hit=%0d miss=%0d at beat %0d, none expected",
                 hit_pulse, miss_pulse, beat_no);
      end else begin
        e = exp_q.pop_front();
        if (hit_pulse != e.hit || beat_no != e.beat || int'(combo) != e.combo) begin
          mismatched++;
          $display("FAIL judge: got hit=%0d beat=%0d combo=%0d, expected hit=%0d beat=%0d combo=%0d",
                   hit_pulse, beat_no, combo, e.hit, e.beat, e.combo);
        end else begin
          $display("judge ok: %s at beat %0d combo %0d", e.hit ? "hit" : "miss", beat_no, combo);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic beat();
    beat_no++;
    game_clock = 1'b1;
    wait_clk(8);
    game_clock = 1'b0;
    wait_clk(8);
  endtask

  // Presents a note, gives the beat that latches it, queues its expected outcome and plays
  // every beat of it except the closing one (which is the next note's latch beat).
  task automatic run_note(input logic [11:0] note, input int hold, input logic [15:0] kv,
                          input int mode, input int gap, input int expk);
    int   len;
    int   lb;
    exp_t e;
    len         = (hold == 0) ? 1 : hold;
    curr_note   = note;
    hold_length = hold[3:0];
    beat();
    lb = beat_no;
    if (expk != E_NONE) begin
      e.hit  = (expk == E_HIT);
      e.beat = (expk == E_MISS_FIRST) ? lb + 1 : lb + len;
      combo_model = (expk == E_HIT) ? ((combo_model >= CMAX) ? CMAX : combo_model + 1) : 0;
      e.combo = combo_model;
      exp_q.push_back(e);
    end
    keys = '0;
    case (mode)
      M_PRESS: begin
        wait_clk(6);
        keys = kv;
        wait_clk(6);
        repeat (len - 1) beat();
      end
      M_GAP: begin
        wait_clk(6);
        keys = kv;
        wait_clk(6);
        beat();
        keys = '0;
        wait_clk(gap);
        keys = kv;
        wait_clk(2);
        repeat (len - 2) beat();
      end
      M_REST: begin
        repeat (len - 1) begin
          for (int k = 0; k < 4; k++) begin
            keys = 16'($urandom);
            wait_clk(3);
          end
          keys = '0;
          beat();
        end
      end
      M_BOUNCE: begin
        for (int i = 0; i < 6; i++) begin
          keys = (i % 2 == 0) ? kv : 16'h0000;
          wait_clk(2);
        end
        keys = kv;
        wait_clk(3);
        check("holding_before_debounce", holding, 0);
        wait_clk(1);
        check("holding_after_debounce", holding, 1);
        repeat (len - 1) beat();
      end
      default: ;
    endcase
  endtask

  initial begin
    reset = 1'b1;
    wait_clk(3);
    check("reset_hit_pulse", hit_pulse, 0);
    check("reset_miss_pulse", miss_pulse, 0);
    check("reset_combo", combo, 0);
    check("reset_max_combo", max_combo, 0);
    check("reset_holding", holding, 0);
    reset = 1'b0;
    wait_clk(2);
    start = 1'b1;
    wait_clk(2);

    run_note(12'h001, 2, 16'h0001, M_PRESS, 0, E_HIT);
    run_note(12'h002, 0, 16'h0002, M_PRESS, 0, E_HIT);   // hold 0 lasts one beat
    check("combo_first_hit", combo, 1);
    check("max_first_hit", max_combo, 1);
    run_note(12'h010, 1, 16'h0010, M_PRESS, 0, E_HIT);
    run_note(12'h004, 1, 16'h0000, M_PRESS, 0, E_MISS_FIRST);
    run_note(12'h004, 1, 16'h0004, M_BOUNCE, 0, E_HIT);
    check("combo_after_miss", combo, 0);
    check("max_kept_after_miss", max_combo, 3);
    run_note(12'h000, 2, 16'h0000, M_REST, 0, E_NONE);
    check("combo_before_rest", combo, 1);
    run_note(12'h008, 3, 16'h0008, M_GAP, 20, E_MISS_CLOSE);
    check("combo_after_rest", combo, 1);
    check("holding_after_long_release", holding, 0);
`ifdef NOTE_JUDGE_RELEASE_GRACE_EN
    run_note(12'h008, 2, 16'h0008, M_GAP, 5, E_HIT);
    check("holding_after_short_release", holding, 1);
`else
    run_note(12'h008, 2, 16'h0008, M_GAP, 5, E_MISS_CLOSE);
    check("holding_after_short_release", holding, 0);
`endif
    run_note(12'h001, 1, 16'h2001, M_PRESS, 0, E_MISS_FIRST);

    for (int i = 0; i < 256; i++) run_note(12'h001, 1, 16'h0001, M_PRESS, 0, E_HIT);

    // Stop the game in the middle of a held note
    run_note(12'h001, 2, 16'h0001, M_PRESS, 0, E_NONE);
    check("holding_before_stop", holding, 1);
    check("combo_saturated", combo, CMAX);
    check("max_saturated", max_combo, CMAX);
    start = 1'b0;
    wait_clk(1);
    check("holding_after_stop", holding, 0);
    check("combo_kept_after_stop", combo, CMAX);
    check("max_kept_after_stop", max_combo, CMAX);
    beat();
    start = 1'b1;
    combo_model = 0;
    wait_clk(2);
    check("combo_cleared_on_start", combo, 0);
    check("max_cleared_on_start", max_combo, 0);

    // Asynchronous reset in the middle of a held note
    run_note(12'h002, 1, 16'h0002, M_PRESS, 0, E_HIT);
    run_note(12'h004, 2, 16'h0004, M_PRESS, 0, E_NONE);
    check("combo_before_reset", combo, 1);
    check("holding_before_reset", holding, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_holding", holding, 0);
    check("async_reset_combo", combo, 0);
    check("async_reset_max", max_combo, 0);
    check("async_reset_hit", hit_pulse, 0);
    check("async_reset_miss", miss_pulse, 0);
    wait_clk(2);
    reset = 1'b0;
    wait_clk(2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
